// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 raster timing constants
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam logic VGA_SYNC_POL = 1'b0;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = span_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = span_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle driven by vga_timing_gen
interface vga_timing_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             frame_start;

    modport master (
        output h_count, v_count, hsync, vsync, video_on, frame_start
    );

    modport slave (
        input  h_count, v_count, hsync, vsync, video_on, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// rtl/vga_timing_gen_wrap_counter.sv - modulo-N counter with enable and terminal-count flag
module wrap_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    // wrap marks the terminal count; the next enabled edge returns to zero
    assign wrap = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/blank decode and frame-start pulse
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_enable;
    logic             frame_start_q;
    logic             hs_active;
    logic             vs_active;
    logic             h_visible;
    logic             v_visible;

    wrap_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (CNT_W)
    ) u_h_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (h_cnt),
        .wrap   (h_wrap)
    );

    // the line counter only advances on the pixel that ends a line
    assign v_enable = enable & h_wrap;

    wrap_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (CNT_W)
    ) u_v_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (v_enable),
        .count  (v_cnt),
        .wrap   (v_wrap)
    );

    // registered from the same edge that moves both counters to (0,0)
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= v_enable & v_wrap;
        end
    end

    always_comb begin
        hs_active = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_active = (v_cnt >= VS_START) && (v_cnt < VS_END);
        h_visible = (h_cnt < H_ACT_END);
        v_visible = (v_cnt < V_ACT_END);
    end

    assign vga.h_count     = h_cnt;
    assign vga.v_count     = v_cnt;
    assign vga.hsync       = hs_active ? SYNC_POL : ~SYNC_POL;
    assign vga.vsync       = vs_active ? SYNC_POL : ~SYNC_POL;
    assign vga.video_on    = h_visible & v_visible;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (full-size and shrunken raster)
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a, en_a, rst_b, en_b;
    int   tests = 0;
    int   fails = 0;
    int   exp_h, exp_v;
    logic exp_fs;

    always #5 clk = ~clk;

    vga_timing_if vif_a ();
    vga_timing_if vif_b ();

    vga_timing_gen dut_a (
        .clk    (clk),
        .reset  (rst_a),
        .enable (en_a),
        .vga    (vif_a)
    );

    // 15 x 11 raster with active-high sync: hsync on h 10..12, vsync on v 7..8
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b1)
    ) dut_b (
        .clk    (clk),
        .reset  (rst_b),
        .enable (en_b),
        .vga    (vif_b)
    );

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (vif_a.h_count !== 10'd0 || vif_a.v_count !== 10'd0) begin fails++; $display("FAIL reset_counts: got %0d,%0d want 0,0", vif_a.h_count, vif_a.v_count); end
            tests++; if ({vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.frame_start} !== 4'b1110) begin fails++; $display("FAIL reset_flags: got %b want 1110", {vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.frame_start}); end
            tests++; if ({vif_b.hsync, vif_b.vsync, vif_b.video_on, vif_b.frame_start} !== 4'b0010) begin fails++; $display("FAIL reset_flags_pol1: got %b want 0010", {vif_b.hsync, vif_b.vsync, vif_b.video_on, vif_b.frame_start}); end
        end
        en_b = 1'b0;
    endtask

    task automatic test_hline();
        rst_a = 1'b0; en_a = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            tests++; if (vif_a.frame_start !== 1'b0) begin fails++; $display("FAIL hline_fs k=%0d: got %b want 0", k, vif_a.frame_start); end
            case (k)
                639: begin tests++; if (vif_a.video_on !== 1'b1 || vif_a.h_count !== 10'd639) begin fails++; $display("FAIL hline_639: got h=%0d vo=%b want 639,1", vif_a.h_count, vif_a.video_on); end end
                640: begin tests++; if (vif_a.video_on !== 1'b0) begin fails++; $display("FAIL hline_640_video: got %b want 0", vif_a.video_on); end end
                655: begin tests++; if (vif_a.hsync !== 1'b1) begin fails++; $display("FAIL hline_655_hsync: got %b want 1", vif_a.hsync); end end
                656: begin tests++; if (vif_a.hsync !== 1'b0 || vif_a.h_count !== 10'd656) begin fails++; $display("FAIL hline_656: got h=%0d hs=%b want 656,0", vif_a.h_count, vif_a.hsync); end end
                751: begin tests++; if (vif_a.hsync !== 1'b0) begin fails++; $display("FAIL hline_751_hsync: got %b want 0", vif_a.hsync); end end
                752: begin tests++; if (vif_a.hsync !== 1'b1) begin fails++; $display("FAIL hline_752_hsync: got %b want 1", vif_a.hsync); end end
                799: begin tests++; if (vif_a.h_count !== 10'd799 || vif_a.v_count !== 10'd0 || vif_a.video_on !== 1'b0) begin fails++; $display("FAIL hline_799: got %0d,%0d vo=%b want 799,0,0", vif_a.h_count, vif_a.v_count, vif_a.video_on); end end
                800: begin tests++; if (vif_a.h_count !== 10'd0 || vif_a.v_count !== 10'd1 || vif_a.video_on !== 1'b1) begin fails++; $display("FAIL hline_wrap: got %0d,%0d vo=%b want 0,1,1", vif_a.h_count, vif_a.v_count, vif_a.video_on); end end
                default: ;
            endcase
        end
    endtask

    task automatic test_divided_enable();
        logic exp_hs;
        exp_h = 0; exp_v = 1;
        for (int i = 0; i < 3200; i++) begin
            en_a = (i % 4 == 0);
            @(negedge clk);
            if (en_a) begin
                if (exp_h == 799) begin exp_h = 0; exp_v = exp_v + 1; end
                else exp_h = exp_h + 1;
            end
            exp_hs = (exp_h >= 656 && exp_h < 752) ? 1'b0 : 1'b1;
            tests++; if (vif_a.h_count !== 10'(exp_h) || vif_a.v_count !== 10'(exp_v) || vif_a.hsync !== exp_hs) begin fails++; $display("FAIL div4 i=%0d: got h=%0d v=%0d hs=%b want %0d,%0d,%b", i, vif_a.h_count, vif_a.v_count, vif_a.hsync, exp_h, exp_v, exp_hs); end
        end
        tests++; if (vif_a.h_count !== 10'd0 || vif_a.v_count !== 10'd2) begin fails++; $display("FAIL div4_line_end: got %0d,%0d want 0,2", vif_a.h_count, vif_a.v_count); end
    endtask

    task automatic test_hold();
        en_a = 1'b1;
        repeat (655) @(negedge clk);
        tests++; if (vif_a.h_count !== 10'd655 || vif_a.hsync !== 1'b1) begin fails++; $display("FAIL hold_pre: got h=%0d hs=%b want 655,1", vif_a.h_count, vif_a.hsync); end
        en_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tests++; if (vif_a.h_count !== 10'd655 || vif_a.v_count !== 10'd2 || vif_a.hsync !== 1'b1 || vif_a.vsync !== 1'b1 || vif_a.video_on !== 1'b0 || vif_a.frame_start !== 1'b0) begin fails++; $display("FAIL hold_frozen i=%0d: got h=%0d v=%0d hs=%b vs=%b vo=%b", i, vif_a.h_count, vif_a.v_count, vif_a.hsync, vif_a.vsync, vif_a.video_on); end
        end
        en_a = 1'b1;
        @(negedge clk);
        tests++; if (vif_a.h_count !== 10'd656 || vif_a.hsync !== 1'b0) begin fails++; $display("FAIL hold_resume: got h=%0d hs=%b want 656,0", vif_a.h_count, vif_a.hsync); end
    endtask

    task automatic test_reset_midframe();
        en_a = 1'b1;
        repeat (444) @(negedge clk);
        tests++; if (vif_a.h_count !== 10'd300 || vif_a.v_count !== 10'd3) begin fails++; $display("FAIL mid_pre: got %0d,%0d want 300,3", vif_a.h_count, vif_a.v_count); end
        rst_a = 1'b1;
        @(negedge clk);
        tests++; if (vif_a.h_count !== 10'd0 || vif_a.v_count !== 10'd0 || vif_a.frame_start !== 1'b0) begin fails++; $display("FAIL mid_reset: got %0d,%0d fs=%b want 0,0,0", vif_a.h_count, vif_a.v_count, vif_a.frame_start); end
        rst_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            tests++; if (vif_a.h_count !== 10'(k) || vif_a.v_count !== 10'd0 || vif_a.frame_start !== 1'b0) begin fails++; $display("FAIL mid_resume k=%0d: got %0d,%0d fs=%b want %0d,0,0", k, vif_a.h_count, vif_a.v_count, vif_a.frame_start, k); end
        end
    endtask

    task automatic test_frame();
        int   n_en, pulses;
        logic e_hs, e_vs, e_vo;
        n_en = 0; pulses = 0;
        exp_h = 0; exp_v = 0; exp_fs = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 2000 && n_en < 330; i++) begin
            en_b = (i % 3 != 1);
            @(negedge clk);
            exp_fs = 1'b0;
            if (en_b) begin
                n_en++;
                if (exp_h == 14) begin
                    exp_h = 0;
                    exp_v = (exp_v == 10) ? 0 : exp_v + 1;
                    exp_fs = (exp_v == 0);
                end else begin
                    exp_h = exp_h + 1;
                end
            end
            e_hs = (exp_h >= 10 && exp_h < 13);
            e_vs = (exp_v >= 7 && exp_v < 9);
            e_vo = (exp_h < 8 && exp_v < 6);
            if (vif_b.frame_start === 1'b1) pulses++;
            tests++; if (vif_b.h_count !== 10'(exp_h) || vif_b.v_count !== 10'(exp_v) || vif_b.hsync !== e_hs || vif_b.vsync !== e_vs || vif_b.video_on !== e_vo || vif_b.frame_start !== exp_fs) begin fails++; $display("FAIL frame i=%0d: got h=%0d v=%0d hs=%b vs=%b vo=%b fs=%b want %0d,%0d,%b,%b,%b,%b", i, vif_b.h_count, vif_b.v_count, vif_b.hsync, vif_b.vsync, vif_b.video_on, vif_b.frame_start, exp_h, exp_v, e_hs, e_vs, e_vo, exp_fs); end
        end
        tests++; if (n_en != 330) begin fails++; $display("FAIL frame_budget: got %0d enables want 330", n_en); end
        tests++; if (pulses != 2) begin fails++; $display("FAIL frame_pulses: got %0d want 2", pulses); end
        tests++; if (vif_b.h_count !== 10'd0 || vif_b.v_count !== 10'd0 || vif_b.frame_start !== 1'b1) begin fails++; $display("FAIL frame_origin: got %0d,%0d fs=%b want 0,0,1", vif_b.h_count, vif_b.v_count, vif_b.frame_start); end
        en_b = 1'b0;
        @(negedge clk);
        tests++; if (vif_b.frame_start !== 1'b0 || vif_b.h_count !== 10'd0) begin fails++; $display("FAIL frame_clear: got fs=%b h=%0d want 0,0", vif_b.frame_start, vif_b.h_count); end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
        test_reset();
        test_hline();
        test_divided_enable();
        test_hold();
        test_reset_midframe();
        test_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
